phys_bus_ctrl: RTL

- Physical-side bus controller directly downstream of the MMU.
- Consumes the MMU's translated request (ce/we/addr/data/16-bit device select) and services it on external asynchronous SRAM or a byte-wide serial port shell.
- Returns read data plus a one-cycle ack, which the MMU samples to advance its state.
- Writes are always full words; partial-word stores are handled upstream by read-modify-write.

---
 rtl/phys_bus_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/phys_bus_ctrl.sv
// phys_bus_ctrl: services translated MMU requests on async SRAM or a byte-wide serial port; `BUS_TIMEOUT_EN adds a serial-write wait timeout.
module phys_bus_ctrl #(
    parameter int RAM_WAIT = 2,
    parameter int SRAM_AW  = 20,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_ce_i,
    input  logic               bus_we_i,
    input  logic [31:0]        bus_addr_i,
    input  logic [31:0]        bus_data_i,
    input  logic [15:0]        bus_sel_i,
    output logic [31:0]        bus_data_o,
    output logic               bus_ack_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    inout  wire  [31:0]        sram_data_io,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [7:0]         uart_tx_data_o,
    output logic               uart_tx_start_o,
    input  logic               uart_tx_busy_i,
    input  logic [7:0]         uart_rx_data_i,
    input  logic               uart_rx_valid_i,
    output logic               uart_rx_ack_o
);
    typedef enum logic [2:0] {IDLE, RAM_ACC, UART_WAIT, ACK, RECOVER} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic we_q, ram_q, drive_q, we_nx, ram_nx;
    logic [31:0] wdata_q, uart_rdata;
    logic req, sel_ram, sel_uart, uart_dat, uart_stat, to_hit, timeout_flag;
    logic unused;
    assign req       = state == IDLE && bus_ce_i;
    assign sel_ram   = bus_sel_i[0];
    assign sel_uart  = ~bus_sel_i[0] & bus_sel_i[1];
    assign uart_dat  = bus_addr_i[3:2] == 2'd0;
    assign uart_stat = bus_addr_i[3:2] == 2'd1;
    assign we_nx     = req ? bus_we_i : we_q;
    assign ram_nx    = req ? sel_ram : ram_q;
    assign uart_rdata = uart_dat ? (uart_rx_valid_i ? {24'd0, uart_rx_data_i} : 32'd0) :
                        uart_stat ? {29'd0, timeout_flag, uart_rx_valid_i, ~uart_tx_busy_i} : 32'd0;
    assign sram_data_io = drive_q ? wdata_q : 32'hz;
    assign unused = ^{bus_addr_i[31:SRAM_AW+2], bus_addr_i[1:0], bus_sel_i[15:2], TIMEOUT[0]};
`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;
    assign to_hit = wcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt         <= '0;
            timeout_flag <= 1'b0;
        end else if (req) begin
            wcnt <= '0;
            if (sel_uart && !bus_we_i && uart_stat) timeout_flag <= 1'b0;
        end else if (state == UART_WAIT && uart_tx_busy_i) begin
            wcnt <= wcnt + TW'(1);
            if (to_hit) timeout_flag <= 1'b1;
        end
    end
`else
    assign to_hit       = 1'b0;
    assign timeout_flag = 1'b0;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (bus_ce_i) state_n = sel_ram ? RAM_ACC :
                           (sel_uart && bus_we_i && uart_dat && uart_tx_busy_i) ? UART_WAIT : ACK;
            RAM_ACC:   if (cnt == 4'd1) state_n = ACK;
            UART_WAIT: if (!uart_tx_busy_i || to_hit) state_n = ACK;
            ACK:       state_n = RECOVER;
            default:   state_n = IDLE;
        endcase
    end
    // strobes are registered from the next state so the SRAM never sees decode glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            we_q            <= 1'b0;
            ram_q           <= 1'b0;
            drive_q         <= 1'b0;
            wdata_q         <= 32'd0;
            bus_data_o      <= 32'd0;
            bus_ack_o       <= 1'b0;
            sram_addr_o     <= '0;
            sram_ce_n_o     <= 1'b1;
            sram_oe_n_o     <= 1'b1;
            sram_we_n_o     <= 1'b1;
            uart_tx_data_o  <= 8'd0;
            uart_tx_start_o <= 1'b0;
            uart_rx_ack_o   <= 1'b0;
        end else begin
            state           <= state_n;
            bus_ack_o       <= state_n == ACK;
            sram_ce_n_o     <= ~(state_n == RAM_ACC || (state_n == ACK && ram_nx && we_nx));
            sram_oe_n_o     <= ~(state_n == RAM_ACC && !we_nx);
            sram_we_n_o     <= ~(state_n == RAM_ACC && we_nx);
            drive_q         <= ram_nx && we_nx && (state_n == RAM_ACC || state_n == ACK);
            uart_tx_start_o <= (req && sel_uart && bus_we_i && uart_dat && !uart_tx_busy_i) ||
                               (state == UART_WAIT && !uart_tx_busy_i);
            uart_rx_ack_o   <= req && sel_uart && !bus_we_i && uart_dat && uart_rx_valid_i;
            if (req) begin
                we_q    <= bus_we_i;
                ram_q   <= sel_ram;
                wdata_q <= bus_data_i;
                cnt     <= 4'(RAM_WAIT);
            end
            if (req && sel_ram) sram_addr_o <= bus_addr_i[SRAM_AW+1:2];
            if (req && sel_uart && bus_we_i && uart_dat) uart_tx_data_o <= bus_data_i[7:0];
            if (req && !bus_we_i && !sel_ram) bus_data_o <= sel_uart ? uart_rdata : 32'd0;
            if (state == RAM_ACC) cnt <= cnt - 4'd1;
            if (state == RAM_ACC && cnt == 4'd1 && !we_q) bus_data_o <= sram_data_io;
        end
    end
endmodule
